// File: rtl/uart_rx_frame_chk.sv
// UART receive framer: start/data(LSB-first)/parity/stop checking on per-bit strobes.
// Result pulses appear one cycle after the stop strobe; there is no backpressure.
module uart_rx_frame_chk #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             SAMPLED_BIT,
  input  logic             BIT_STB,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             perr_lat_q, perr_lat_d;
  logic             dv_q, dv_d;
  logic             par_err_q, par_err_d;
  logic             stp_err_q, stp_err_d;
  logic             par_exp;

  // Parity bit the transmitter should have sent for the word now held in shift_q.
  assign par_exp = PAR_TYP ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    pdata_d    = pdata_q;
    perr_lat_d = perr_lat_q;
    dv_d       = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    if (BIT_STB) begin
      case (state_q)
        IDLE: begin
          if (!SAMPLED_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // New bit enters at the MSB so the first data bit ends up in bit 0.
          shift_d = WIDTH'({SAMPLED_BIT, shift_q} >> 1);
          if (cnt_q == LAST_BIT) begin
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (SAMPLED_BIT != par_exp) begin
            perr_lat_d = 1'b1;
          end
          state_d = STOP;
        end
        STOP: begin
          if (!SAMPLED_BIT) begin
            stp_err_d = 1'b1;
          end else if (perr_lat_q) begin
            par_err_d = 1'b1;
          end else begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end
          perr_lat_d = 1'b0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      pdata_q    <= '0;
      perr_lat_q <= 1'b0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      pdata_q    <= pdata_d;
      perr_lat_q <= perr_lat_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Bench for uart_rx_frame_chk: directed frame table, reset corner cases, then random frames vs a parity model.
module tb_uart_rx_frame_chk;

  logic       CLK;
  logic       RST;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       SAMPLED_BIT;
  logic       BIT_STB;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       BUSY;

  int total = 0;
  int bad   = 0;
  logic [7:0] cur_pd;

  uart_rx_frame_chk #(.WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .SAMPLED_BIT (SAMPLED_BIT),
    .BIT_STB     (BIT_STB),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_ERR     (PAR_ERR),
    .STP_ERR     (STP_ERR),
    .BUSY        (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Outcome kinds: 0 good word, 1 parity error, 2 stop error.
  typedef struct {
    logic       pe;
    logic       pt;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    int         gap;
    int         kind;
    logic [7:0] exp_pd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called and returns at a negedge; samples after each strobe land at the following negedge.
  task automatic strobe(input logic b);
    BIT_STB     = 1'b1;
    SAMPLED_BIT = b;
    @(negedge CLK);
    BIT_STB     = 1'b0;
    SAMPLED_BIT = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic pe, input logic pt, input logic [7:0] d,
                            input logic pb, input logic sb, input int gap,
                            input int kind, input logic [7:0] exp_pd);
    logic bits[$];
    bit   last;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(sb);
    PAR_EN  = pe;
    PAR_TYP = pt;
    for (int i = 0; i < bits.size(); i++) begin
      strobe(bits[i]);
      last = (i == bits.size() - 1);
      if (last) begin
        chk("data_valid", 32'(DATA_VALID), 32'(kind == 0));
        chk("par_err",    32'(PAR_ERR),    32'(kind == 1));
        chk("stp_err",    32'(STP_ERR),    32'(kind == 2));
        chk("busy_end",   32'(BUSY), 0);
        chk("p_data_end", 32'(P_DATA), 32'(exp_pd));
        cur_pd = exp_pd;
      end else begin
        chk("quiet", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 0);
        chk("busy", 32'(BUSY), 1);
        chk("p_data_hold", 32'(P_DATA), 32'(cur_pd));
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        chk("quiet_gap", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 0);
        chk("busy_gap", 32'(BUSY), last ? 0 : 1);
      end
    end
  endtask

  task automatic idle_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(1'b1);
      chk("idle_quiet", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 0);
      chk("idle_busy", 32'(BUSY), 0);
      chk("idle_p_data", 32'(P_DATA), 32'(cur_pd));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic       pe, pt, pb, sb, pexp;
    logic [7:0] d;
    int         ones, kind;

    vecs.push_back('{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2, 0, 8'hA5});
    vecs.push_back('{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5});
    vecs.push_back('{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1, 1, 8'hA5});
    vecs.push_back('{1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 0, 0, 8'h07});
    vecs.push_back('{1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 3, 1, 8'h07});
    vecs.push_back('{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1, 2, 8'h07});
    vecs.push_back('{1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 0, 2, 8'h07});
    vecs.push_back('{1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0, 0, 8'h55});
    vecs.push_back('{1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 0, 0, 8'hAA});

    RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; SAMPLED_BIT = 1'b1; BIT_STB = 1'b0;
    cur_pd = 8'h00;
    repeat (2) @(negedge CLK);
    chk("rst_p_data", 32'(P_DATA), 0);
    chk("rst_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RST = 1'b0;
    @(negedge CLK);

    idle_strobes(3);
    foreach (vecs[i])
      send_frame(vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].pb, vecs[i].sb,
                 vecs[i].gap, vecs[i].kind, vecs[i].exp_pd);

    // Idle strobes between two good frames must not disturb anything.
    idle_strobes(4);
    send_frame(1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1, 0, 8'h55);
    idle_strobes(2);
    send_frame(1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1, 0, 8'hAA);

    // Stop error followed immediately by a start strobe: treated as a new frame.
    send_frame(1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 0, 2, 8'hAA);
    send_frame(1'b0, 1'b0, 8'h34, 1'b0, 1'b1, 0, 0, 8'h34);

    // Asynchronous reset in the middle of a frame.
    PAR_EN = 1'b0;
    strobe(1'b0);
    strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b1);
    chk("busy_before_rst", 32'(BUSY), 1);
    #2 RST = 1'b1;
    #1;
    chk("midrst_p_data", 32'(P_DATA), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 0);
    @(negedge CLK);
    RST = 1'b0;
    cur_pd = 8'h00;
    @(negedge CLK);
    chk("postrst_quiet", 32'({DATA_VALID, PAR_ERR, STP_ERR, BUSY}), 0);
    send_frame(1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1, 0, 8'h81);

    // Random frames checked against a parity-counting model.
    for (int n = 0; n < 150; n++) begin
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 4) != 0);
      ones = $countones(d);
      pexp = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (!sb) kind = 2;
      else if (pe && (pb != pexp)) kind = 1;
      else kind = 0;
      send_frame(pe, pt, d, pb, sb, $urandom_range(0, 3), kind, (kind == 0) ? d : cur_pd);
      idle_strobes($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
